// File: rtl/wb_commit.sv
`default_nettype none
// ============================================================================
// Module      : wb_commit
// Description : Writeback/commit stage. Accepts at most one completed result
//               per cycle from the LSU (priority) or the ALU, registers it
//               toward the register file and the scoreboard release port,
//               and on a taken branch/jump issues a one-cycle PC redirect
//               followed by a timed flush during which results are drained.
//               Optional feature macro: WB_BYPASS_EN (adds the combinational
//               byp_valid / byp_rd / byp_data forwarding outputs).
// Revision    : 1.0 - initial release
// ============================================================================
module wb_commit #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    // ALU completion port
    input  logic            alu_valid,
    input  logic [XLEN-1:0] alu_result,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_target,
    input  logic            alu_target_valid,
    output logic            alu_ok,
    // LSU completion port
    input  logic            lsu_valid,
    input  logic [XLEN-1:0] lsu_data,
    input  logic [4:0]      lsu_rd,
    output logic            lsu_ok,
    // Register file write port
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    // Scoreboard release
    output logic            rel_valid,
    output logic [4:0]      rel_rd,
    // Redirect / flush
    output logic [XLEN-1:0] target_o,
    output logic            target_valid_o,
    output logic            flush_o
`ifdef WB_BYPASS_EN
    ,
    output logic            byp_valid,
    output logic [4:0]      byp_rd,
    output logic [XLEN-1:0] byp_data
`endif
);

    // Two-state controller: normal commit or draining wrong-path results
    localparam logic [0:0] c_ST_RUN   = 1'b0;
    localparam logic [0:0] c_ST_FLUSH = 1'b1;

    // Flush length as loaded into the 4-bit down-counter (legal range 1..15)
    localparam logic [3:0] c_FLUSH_LOAD = 4'(FLUSH_CYCLES);

    logic [0:0]      r_state;
    logic [3:0]      r_cnt;

    logic            w_in_run;
    logic            w_acc_lsu;
    logic            w_acc_alu;
    logic            w_acc;
    logic [4:0]      w_acc_rd;
    logic [XLEN-1:0] w_acc_data;
    logic            w_redirect;

    assign w_in_run = (r_state == c_ST_RUN);

    // Handshake and selection of the entry committed this cycle.
    // LSU entries are always older, so they win; in FLUSH both sides are
    // simply drained. Nothing is consumed while reset is held.
    always_comb begin
        lsu_ok     = lsu_valid & ~rst;
        alu_ok     = alu_valid & ~rst & (~w_in_run | ~lsu_valid);

        w_acc_lsu  = w_in_run & lsu_ok;
        w_acc_alu  = w_in_run & alu_ok;
        w_acc      = w_acc_lsu | w_acc_alu;

        w_acc_rd   = w_acc_lsu ? lsu_rd   : alu_rd;
        w_acc_data = w_acc_lsu ? lsu_data : alu_result;

        // A redirect only counts when its carrier is actually committed
        w_redirect = w_acc_alu & alu_target_valid;
    end

`ifdef WB_BYPASS_EN
    // Same-cycle forwarding copy of the committing entry; x0 is never forwarded
    always_comb begin
        byp_valid = w_acc & (w_acc_rd != 5'd0);
        byp_rd    = w_acc_rd;
        byp_data  = w_acc_data;
    end
`else
    // Without bypass, consumers observe results only through the register file
`endif

    // Control FSM: enter FLUSH on a committed redirect, count down, resume RUN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_RUN;
            r_cnt   <= 4'd0;
            flush_o <= 1'b0;
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    if (w_redirect) begin
                        r_state <= c_ST_FLUSH;
                        r_cnt   <= c_FLUSH_LOAD;
                        flush_o <= 1'b1;
                    end else begin
                        flush_o <= 1'b0;
                    end
                end
                c_ST_FLUSH: begin
                    // The count holds the number of flush cycles still to run
                    // including the current one; the last one returns to RUN.
                    if (r_cnt <= 4'd1) begin
                        r_state <= c_ST_RUN;
                        r_cnt   <= 4'd0;
                        flush_o <= 1'b0;
                    end else begin
                        r_cnt   <= r_cnt - 4'd1;
                        flush_o <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_RUN;
                    r_cnt   <= 4'd0;
                    flush_o <= 1'b0;
                end
            endcase
        end
    end

    // Writeback register: one-cycle strobes, address/data hold when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we     <= 1'b0;
            rf_waddr  <= 5'd0;
            rf_wdata  <= '0;
            rel_valid <= 1'b0;
            rel_rd    <= 5'd0;
        end else if (w_acc) begin
            // x0 is never written but is still released in the scoreboard
            rf_we     <= (w_acc_rd != 5'd0);
            rf_waddr  <= w_acc_rd;
            rf_wdata  <= w_acc_data;
            rel_valid <= 1'b1;
            rel_rd    <= w_acc_rd;
        end else begin
            rf_we     <= 1'b0;
            rel_valid <= 1'b0;
        end
    end

    // Redirect register: target captured with a single-cycle strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target_o       <= '0;
            target_valid_o <= 1'b0;
        end else begin
            target_valid_o <= w_redirect;
            if (w_redirect) begin
                target_o <= alu_target;
            end
        end
    end

endmodule
`default_nettype wire
